// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: edge-detects up to 8 request lines into a sticky
// pending register and issues their binary indices one at a time, in
// priority order, over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   enable       1 = capture new events and issue codes, 0 = freeze both
//   req_in[7:0]  request lines, each rising edge is one event
//   ready_in     consumer accepts code_out this cycle
//   code_out     binary index of the issued request (registered)
//   valid_out    code_out is valid (registered)
//   pending_out  current pending register
//   pending_cnt  population count of pending_out (combinational, 0..8)
//   overflow     one-cycle pulse when an event merges into a pending bit
module priority_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req_in,
  input  logic       ready_in,
  output logic [2:0] code_out,
  output logic       valid_out,
  output logic [7:0] pending_out,
  output logic [3:0] pending_cnt,
  output logic       overflow
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    pending, pending_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic                valid_nxt;
  logic                overflow_nxt;

  logic [N_REQ-1:0]    ev;
  logic [N_REQ-1:0]    set_mask;
  logic [N_REQ-1:0]    clr_mask;
  logic [CODE_W-1:0]   sel;
  logic                load;

  // Priority select from the registered pending value only.
  always_comb begin
    sel = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N_REQ); i++)
        if (pending[i]) sel = CODE_W'(i);
    end else begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--)
        if (pending[i]) sel = CODE_W'(i);
    end
  end

  // Population count of the pending register.
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < int'(N_REQ); i++)
      pending_cnt = pending_cnt + CNT_W'(pending[i]);
  end

  // Next-state, pending update and registered-output values.
  always_comb begin
    state_nxt    = state;
    code_nxt     = code_out;
    valid_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    ev           = req_in & ~req_q;
    set_mask     = enable ? ev : '0;
    // A new code is loaded from IDLE, or back-to-back when the held one is taken.
    load         = enable && (pending != '0) && ((state == IDLE) || ready_in);
    clr_mask     = load ? (N_REQ'(1) << sel) : '0;
    // Set after clear: an event on the bit being loaded re-queues it.
    pending_nxt  = (pending & ~clr_mask) | set_mask;
    overflow_nxt = enable && ((ev & pending & ~clr_mask) != '0);

    if (load) code_nxt = sel;

    case (state)
      IDLE:    if (load) state_nxt = PRESENT;
      PRESENT: if (ready_in && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    valid_nxt = (state_nxt == PRESENT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      code_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_in;
      pending   <= pending_nxt;
      code_out  <= code_nxt;
      valid_out <= valid_nxt;
      overflow  <= overflow_nxt;
    end
  end

  assign pending_out = pending;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3: directed bench driving two encoders (high-first
// and low-first priority) from shared inputs and checking each against
// hand-computed values.
module tb_priority_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] req_in;
  logic       ready_in;

  logic [2:0] code_h, code_l;
  logic       valid_h, valid_l;
  logic [7:0] pend_h, pend_l;
  logic [3:0] cnt_h, cnt_l;
  logic       ovf_h, ovf_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  priority_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in), .ready_in(ready_in),
    .code_out(code_h), .valid_out(valid_h), .pending_out(pend_h),
    .pending_cnt(cnt_h), .overflow(ovf_h)
  );

  priority_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in), .ready_in(ready_in),
    .code_out(code_l), .valid_out(valid_l), .pending_out(pend_l),
    .pending_cnt(cnt_l), .overflow(ovf_l)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_in = '0; ready_in = 1'b0;
    tick();
    chk("rst_valid_h", valid_h, 0);
    chk("rst_code_h",  code_h, 0);
    chk("rst_pend_h",  pend_h, 0);
    chk("rst_cnt_l",   cnt_l, 0);
    chk("rst_ovf_l",   ovf_l, 0);
    rst = 1'b0;

    // 1: single pulse on bit 5, two-cycle latency, one-cycle valid
    enable = 1'b1; ready_in = 1'b1;
    req_in = 8'h20;
    tick();
    chk("t1_valid_early", valid_h, 0);
    chk("t1_pend", pend_h, 8'h20);
    req_in = 8'h00;
    tick();
    chk("t1_valid_h", valid_h, 1);
    chk("t1_code_h",  code_h, 5);
    chk("t1_code_l",  code_l, 5);
    chk("t1_cnt_h",   cnt_h, 0);
    tick();
    chk("t1_valid_off", valid_h, 0);

    // 2: three simultaneous events, issued back-to-back in priority order
    req_in = 8'h85;
    tick();
    chk("t2_pend", pend_h, 8'h85);
    chk("t2_cnt",  cnt_h, 3);
    req_in = 8'h00;
    tick();
    chk("t2_c0_h", code_h, 7); chk("t2_c0_l", code_l, 0);
    chk("t2_v0_h", valid_h, 1); chk("t2_v0_l", valid_l, 1);
    tick();
    chk("t2_c1_h", code_h, 2); chk("t2_c1_l", code_l, 2);
    chk("t2_v1_h", valid_h, 1);
    tick();
    chk("t2_c2_h", code_h, 0); chk("t2_c2_l", code_l, 7);
    chk("t2_v2_l", valid_l, 1);
    tick();
    chk("t2_end_h", valid_h, 0); chk("t2_end_l", valid_l, 0);

    // 3: backpressure holds the code stable
    ready_in = 1'b0;
    req_in = 8'h0A;
    tick();
    req_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_code_h", code_h, 3);
      chk("t3_hold_valid_h", valid_h, 1);
      chk("t3_hold_code_l", code_l, 1);
    end
    chk("t3_pend_h", pend_h, 8'h02);
    chk("t3_cnt_h",  cnt_h, 1);
    chk("t3_pend_l", pend_l, 8'h08);
    ready_in = 1'b1;
    tick();
    chk("t3_next_h", code_h, 1); chk("t3_next_l", code_l, 3);
    chk("t3_next_v", valid_h, 1);
    tick();
    chk("t3_end", valid_h, 0);

    // 4: overflow on a pending bit; re-request on the held / loading index
    ready_in = 1'b0;
    req_in = 8'h30;
    tick();
    req_in = 8'h00;
    tick();
    chk("t4_code_h", code_h, 5); chk("t4_code_l", code_l, 4);
    req_in = 8'h10;
    tick();
    chk("t4_ovf_h",  ovf_h, 1);
    chk("t4_cnt_h",  cnt_h, 1);
    chk("t4_ovf_l",  ovf_l, 0);
    chk("t4_pend_l", pend_l, 8'h30);
    req_in = 8'h00;
    tick();
    chk("t4_ovf_drop", ovf_h, 0);
    ready_in = 1'b1;
    req_in = 8'h10;
    tick();
    chk("t4_ld_code_h", code_h, 4); chk("t4_ld_pend_h", pend_h, 8'h10);
    chk("t4_ld_ovf_h",  ovf_h, 0);
    chk("t4_ld_code_l", code_l, 4); chk("t4_ld_pend_l", pend_l, 8'h30);
    chk("t4_ld_ovf_l",  ovf_l, 0);
    req_in = 8'h00;
    tick();
    chk("t4_again_h", code_h, 4); chk("t4_again_v", valid_h, 1);
    chk("t4_again_l", code_l, 4);
    tick();
    chk("t4_done_h", valid_h, 0); chk("t4_last_l", code_l, 5);
    tick();
    chk("t4_done_l", valid_l, 0);

    // 5: disabled capture, and accept-without-reload while disabled
    enable = 1'b0;
    req_in = 8'h42;
    tick();
    req_in = 8'h00;
    tick();
    chk("t5_pend", pend_h, 0); chk("t5_valid", valid_h, 0);
    enable = 1'b1; ready_in = 1'b0;
    req_in = 8'h81;
    tick();
    req_in = 8'h00;
    tick();
    chk("t5_code_h", code_h, 7); chk("t5_code_l", code_l, 0);
    enable = 1'b0; ready_in = 1'b1;
    tick();
    chk("t5_acc_v_h", valid_h, 0); chk("t5_acc_v_l", valid_l, 0);
    chk("t5_keep_h", pend_h, 8'h01); chk("t5_keep_l", pend_l, 8'h80);
    tick();
    chk("t5_noreload", valid_h, 0);

    // 6: asynchronous reset mid-handshake, then event from a held-high line
    rst = 1'b1; #2; rst = 1'b0;
    enable = 1'b1; ready_in = 1'b0;
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'hF0;
    tick();
    chk("t6_pre_pend", pend_h, 8'hF0); chk("t6_pre_valid", valid_h, 1);
    req_in = 8'h00;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", valid_h, 0);
    chk("t6_rst_code",  code_h, 0);
    chk("t6_rst_pend",  pend_h, 0);
    chk("t6_rst_cnt",   cnt_h, 0);
    chk("t6_rst_ovf",   ovf_h, 0);
    req_in = 8'h08;
    #2;
    rst = 1'b0;
    tick();
    chk("t6_e1_valid", valid_h, 0); chk("t6_e1_pend", pend_h, 8'h08);
    tick();
    chk("t6_e2_valid", valid_h, 1); chk("t6_e2_code", code_h, 3);
    chk("t6_e2_code_l", code_l, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
